// File: rtl/fifo_n_pkg.sv
// Shared helpers for the N-entry method FIFO: wrap-aware pointer increment,
// counter-width derivation and the reset levels of the method guards.
package fifo_n_pkg;

  // Guard levels held while RST is asserted: room to enqueue, nothing to dequeue.
  localparam logic ENQ_RDY_RST = 1'b1;
  localparam logic DEQ_RDY_RST = 1'b0;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap at depth-1 so non-power-of-2 depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_n_storage.sv
// WIDTH x DEPTH register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module fifo_n_storage #(
  parameter int WIDTH = 384,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry when the write enable is asserted.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_n_pipe.sv
// N-entry guarded-method FIFO (in_enq / out_deq / out_first with ENA/RDY).
// Circular buffer with head/tail pointers and an occupancy counter.
// Optional macro FIFO_N_PIPELINE_FULL_EN: lets a full FIFO accept an enqueue
// in the same cycle as a dequeue, which creates a combinational
// out_deq__ENA -> in_enq__RDY path.
module fifo_n_pipe
  import fifo_n_pkg::*;
#(
  parameter  int WIDTH = 384,
  parameter  int DEPTH = 4,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [WIDTH-1:0] out_first,
  output logic             out_first__RDY,
  output logic [CW-1:0]    out_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          not_full_q;
  logic          not_empty_q;
  logic          enq_fire;
  logic          deq_fire;

  // Guards are registered flags derived from the next count, so RDY
  // outputs carry no path from any ENA in the baseline build.
`ifdef FIFO_N_PIPELINE_FULL_EN
  assign in_enq__RDY = not_full_q || out_deq__ENA;
`else
  assign in_enq__RDY = not_full_q;
`endif
  assign out_deq__RDY   = not_empty_q;
  assign out_first__RDY = not_empty_q;
  assign out_count      = count_q;

  assign enq_fire = in_enq__ENA && in_enq__RDY;
  assign deq_fire = out_deq__ENA && out_deq__RDY;

  // Next occupancy: simultaneous enq and deq leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (enq_fire && !deq_fire)      count_d = count_q + 1'b1;
    else if (deq_fire && !enq_fire) count_d = count_q - 1'b1;
  end

  // Pointers, counter and guard flags; RST clears them without waiting for CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      not_full_q  <= ENQ_RDY_RST;
      not_empty_q <= DEQ_RDY_RST;
    end else begin
      count_q     <= count_d;
      not_full_q  <= (count_d != CW'(DEPTH));
      not_empty_q <= (count_d != '0);
      if (enq_fire) tail_q <= AW'(ptr_inc(int'(tail_q), DEPTH));
      if (deq_fire) head_q <= AW'(ptr_inc(int'(head_q), DEPTH));
    end
  end

  fifo_n_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .CLK   (CLK),
    .we    (enq_fire),
    .waddr (tail_q),
    .wdata (in_enq_v),
    .raddr (head_q),
    .rdata (out_first)
  );

endmodule

// File: tb/tb_fifo_n_pipe.sv
// Directed bench for fifo_n_pipe: a vector table for the basic
// fill/drain/simultaneous behaviour, hand sequences for async reset,
// held requests, pointer wrap (DEPTH 4 and 3) and the full-pipeline case.
module tb_fifo_n_pipe;

`ifdef FIFO_N_PIPELINE_FULL_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_enq__ENA = 1'b0;
  logic [15:0] in_enq_v = '0;
  logic        in_enq__RDY;
  logic        out_deq__ENA = 1'b0;
  logic        out_deq__RDY;
  logic [15:0] out_first;
  logic        out_first__RDY;
  logic [2:0]  out_count;

  logic        d3_enq = 1'b0;
  logic [15:0] d3_v = '0;
  logic        d3_enq_rdy;
  logic        d3_deq = 1'b0;
  logic        d3_deq_rdy;
  logic [15:0] d3_first;
  logic        d3_first_rdy;
  logic [1:0]  d3_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  fifo_n_pipe #(.WIDTH(16), .DEPTH(4)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .in_enq__ENA    (in_enq__ENA),
    .in_enq_v       (in_enq_v),
    .in_enq__RDY    (in_enq__RDY),
    .out_deq__ENA   (out_deq__ENA),
    .out_deq__RDY   (out_deq__RDY),
    .out_first      (out_first),
    .out_first__RDY (out_first__RDY),
    .out_count      (out_count)
  );

  fifo_n_pipe #(.WIDTH(16), .DEPTH(3)) dut3 (
    .CLK            (CLK),
    .RST            (RST),
    .in_enq__ENA    (d3_enq),
    .in_enq_v       (d3_v),
    .in_enq__RDY    (d3_enq_rdy),
    .out_deq__ENA   (d3_deq),
    .out_deq__RDY   (d3_deq_rdy),
    .out_first      (d3_first),
    .out_first__RDY (d3_first_rdy),
    .out_count      (d3_count)
  );

  typedef struct {
    logic        rst;
    logic        enq;
    logic        deq;
    logic [15:0] data;
    logic        x_enq_rdy;
    logic        x_deq_rdy;
    logic [2:0]  x_count;
    logic        chk_first;
    logic [15:0] x_first;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic enq, input logic deq,
                              input logic [15:0] data, input logic x_enq_rdy,
                              input logic x_deq_rdy, input logic [2:0] x_count,
                              input logic chk_first, input logic [15:0] x_first);
    vec_t v;
    v.rst = rst; v.enq = enq; v.deq = deq; v.data = data;
    v.x_enq_rdy = x_enq_rdy; v.x_deq_rdy = x_deq_rdy; v.x_count = x_count;
    v.chk_first = chk_first; v.x_first = x_first;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock with the given requests; ENAs drop after the edge so the
  // checks that follow see registered state only.
  task automatic step(input logic rst, input logic e, input logic d, input logic [15:0] v);
    @(negedge CLK);
    RST = rst; in_enq__ENA = e; out_deq__ENA = d; in_enq_v = v;
    @(posedge CLK);
    #1;
    in_enq__ENA = 1'b0; out_deq__ENA = 1'b0;
    #1;
  endtask

  task automatic step3(input logic e, input logic d, input logic [15:0] v);
    @(negedge CLK);
    d3_enq = e; d3_deq = d; d3_v = v;
    @(posedge CLK);
    #1;
    d3_enq = 1'b0; d3_deq = 1'b0;
    #1;
  endtask

  initial begin
    // rst enq deq data | enq_rdy deq_rdy count chk_first first
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 3'd0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 3'd0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 3'd0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 16'h00A1, 1, 1, 3'd1, 1, 16'h00A1));
    vecs.push_back(mk(0, 1, 0, 16'h00A2, 1, 1, 3'd2, 1, 16'h00A1));
    vecs.push_back(mk(0, 1, 0, 16'h00A3, 1, 1, 3'd3, 1, 16'h00A1));
    vecs.push_back(mk(0, 1, 0, 16'h00A4, 0, 1, 3'd4, 1, 16'h00A1));
    vecs.push_back(mk(0, 1, 0, 16'h00A5, 0, 1, 3'd4, 1, 16'h00A1));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 1, 1, 3'd3, 1, 16'h00A2));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 1, 1, 3'd2, 1, 16'h00A3));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 1, 1, 3'd1, 1, 16'h00A4));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 1, 0, 3'd0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 1, 0, 3'd0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 16'h0010, 1, 1, 3'd1, 1, 16'h0010));
    vecs.push_back(mk(0, 1, 0, 16'h0011, 1, 1, 3'd2, 1, 16'h0010));
    vecs.push_back(mk(0, 1, 1, 16'h0012, 1, 1, 3'd2, 1, 16'h0011));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 1, 1, 3'd1, 1, 16'h0012));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 1, 0, 3'd0, 0, 16'h0000));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].enq, vecs[i].deq, vecs[i].data);
      chk($sformatf("v%0d enq_rdy", i), 32'(in_enq__RDY), 32'(vecs[i].x_enq_rdy));
      chk($sformatf("v%0d deq_rdy", i), 32'(out_deq__RDY), 32'(vecs[i].x_deq_rdy));
      chk($sformatf("v%0d first_rdy", i), 32'(out_first__RDY), 32'(vecs[i].x_deq_rdy));
      chk($sformatf("v%0d count", i), 32'(out_count), 32'(vecs[i].x_count));
      if (vecs[i].chk_first)
        chk($sformatf("v%0d first", i), 32'(out_first), 32'(vecs[i].x_first));
    end

    // Async reset mid-stream with count=3: clears before the next CLK edge.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0020 + 16'(i));
    chk("pre_rst count", 32'(out_count), 32'd3);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("async_rst count", 32'(out_count), 32'd0);
    chk("async_rst enq_rdy", 32'(in_enq__RDY), 32'd1);
    chk("async_rst deq_rdy", 32'(out_deq__RDY), 32'd0);
    chk("async_rst first_rdy", 32'(out_first__RDY), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Deq held on empty for 5 cycles.
    @(negedge CLK);
    out_deq__ENA = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("empty_deq%0d count", i), 32'(out_count), 32'd0);
      chk($sformatf("empty_deq%0d rdy", i), 32'(out_deq__RDY), 32'd0);
    end
    out_deq__ENA = 1'b0;
    // First enq after a string of empty deqs must land in slot 0 order.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0040 + 16'(i));
    // Enq held on full for 5 cycles.
    @(negedge CLK);
    in_enq__ENA = 1'b1;
    in_enq_v = 16'h00EE;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("full_enq%0d count", i), 32'(out_count), 32'd4);
      chk($sformatf("full_enq%0d first", i), 32'(out_first), 32'h40);
    end
    in_enq__ENA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_drain%0d", i), 32'(out_first), 32'h40 + 32'(i));
      step(0, 0, 1, 16'h0000);
    end
    chk("full_drain empty", 32'(out_deq__RDY), 32'd0);

    // Pointer wrap, DEPTH=4: three fill/drain rounds with an offset start.
    step(0, 1, 0, 16'h0050);
    step(0, 0, 1, 16'h0000);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0100 * 16'(r + 1) + 16'(i));
      chk($sformatf("wrap4 r%0d full", r), 32'(in_enq__RDY), 32'd0);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wrap4 r%0d d%0d", r, i), 32'(out_first), 32'h100 * 32'(r + 1) + 32'(i));
        step(0, 0, 1, 16'h0000);
      end
      chk($sformatf("wrap4 r%0d count", r), 32'(out_count), 32'd0);
    end

    // Pointer wrap, DEPTH=3 (non power of 2).
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) step3(1'b1, 1'b0, 16'h0300 + 16'(r * 16 + i));
      chk($sformatf("wrap3 r%0d count", r), 32'(d3_count), 32'd3);
      chk($sformatf("wrap3 r%0d enq_rdy", r), 32'(d3_enq_rdy), 32'd0);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("wrap3 r%0d d%0d", r, i), 32'(d3_first), 32'h300 + 32'(r * 16 + i));
        step3(1'b0, 1'b1, 16'h0000);
      end
      chk($sformatf("wrap3 r%0d empty", r), 32'(d3_first_rdy), 32'd0);
      step3(1'b1, 1'b0, 16'h03FF);
      step3(1'b0, 1'b1, 16'h0000);
    end

    // Full FIFO, enq+deq in the same cycle.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h00B0 + 16'(i));
    @(negedge CLK);
    in_enq__ENA = 1'b1; in_enq_v = 16'h00B4; out_deq__ENA = 1'b1;
    #1;
    chk("pipe enq_rdy", 32'(in_enq__RDY), 32'(PIPE));
    @(posedge CLK); #1;
    in_enq__ENA = 1'b0; out_deq__ENA = 1'b0;
    #1;
    chk("pipe count", 32'(out_count), PIPE ? 32'd4 : 32'd3);
    chk("pipe first", 32'(out_first), 32'hB1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pipe drain%0d", i), 32'(out_first), 32'hB1 + 32'(i));
      step(0, 0, 1, 16'h0000);
    end
    chk("pipe tail rdy", 32'(out_deq__RDY), 32'(PIPE));
    if (PIPE) chk("pipe B4 fourth", 32'(out_first), 32'hB4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_n_pipe.md
Name: fifo_n_pipe

Overview:
- Parametrised N-entry successor to the single-entry method FIFO. Same guarded-method interface: in_enq, out_deq, out_first, each with ENA/RDY.
- Holds up to DEPTH words of WIDTH bits in a circular buffer with head/tail pointers and an occupancy counter.
- Sits between producer and consumer rules as a decoupling buffer. Adds an occupancy output and optional full-pipeline enqueue.

Parameters:
- WIDTH, 384: data word width in bits (>=1).
- DEPTH, 4: number of entries (>=2, any integer, need not be a power of 2).
- CW, $clog2(DEPTH+1): counter width (derived, localparam).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- in_enq__ENA  input  1  enqueue request.
- in_enq_v  input  WIDTH  enqueue data.
- in_enq__RDY  output  1  enqueue ready.
- out_deq__ENA  input  1  dequeue request.
- out_deq__RDY  output  1  dequeue ready.
- out_first  output  WIDTH  head entry data.
- out_first__RDY  output  1  head valid.
- out_count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, RST=1): head=0, tail=0, count=0; in_enq__RDY=1, out_deq__RDY=0, out_first__RDY=0, out_count=0. Storage contents are not reset; out_first is don't-care while empty.
- Effective enable: enq_fire = in_enq__ENA && in_enq__RDY; deq_fire = out_deq__ENA && out_deq__RDY. An ENA without RDY is ignored; no state changes.
- in_enq__RDY = (count != DEPTH) in the baseline.
- out_deq__RDY = out_first__RDY = (count != 0).
- out_first = mem[head]. Combinational from registers; no path from any ENA.
- enq_fire: mem[tail] <= in_enq_v; tail <= (tail==DEPTH-1) ? 0 : tail+1.
- deq_fire: head <= (head==DEPTH-1) ? 0 : head+1. Data is not cleared.
- count: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Latency: data enqueued at edge k is visible on out_first after edge k when the FIFO was empty (1-cycle enq-to-first). No empty bypass.
- Simultaneous enq+deq with 0<count<DEPTH: both fire, count holds, order is preserved.
- Empty plus deq request: not fired.
- Full plus enq request: not fired (baseline).
- Pointer wrap: explicit compare at DEPTH-1, with no reliance on power-of-2 overflow.
- Reset asserted mid-operation: immediate clear of head, tail and count on the RST edge, independent of CLK. All RDYs take their reset values the same cycle.
- Reset deassertion is synchronised by the surrounding design. This block requires no extra logic for it.

Optional Feature:
- Macro FIFO_N_PIPELINE_FULL_EN.
- Defined: in_enq__RDY = (count != DEPTH) || out_deq__ENA. When full, enq and deq may fire in the same cycle; the head is consumed and the new word is written at tail (== head slot); count stays DEPTH. This adds a combinational path out_deq__ENA -> in_enq__RDY, and it is documented at the integration level.
- Undefined: baseline behaviour, no ENA-to-RDY paths.

Decomposition:
- Package fifo_n_pkg holds:
  - function ptr_inc(ptr, depth) for wrap-aware increment.
  - localparam helper for counter width.
  - Shared reset-value constants (RDY reset levels).
- One natural sub-module, fifo_n_storage: a WIDTH x DEPTH register array with one write port (we, waddr, wdata) and one async read port (raddr -> rdata).
- The top level holds the pointers, the counter and the method guards.

Test Plan:
- Reset then idle: RST=1 for 2 cycles -> in_enq__RDY=1, out_deq__RDY=0, out_first__RDY=0, out_count=0. Assert RST mid-stream with count=3 -> count=0 immediately, before the next CLK.
- Fill to full, DEPTH=4: enq 0xA1,0xA2,0xA3,0xA4 on consecutive cycles -> out_count=4 and in_enq__RDY=0. A 5th enq of 0xA5 is ignored and out_first stays 0xA1.
- Drain with order and wrap: deq 4 times -> out_first reads 0xA1,0xA2,0xA3,0xA4, then out_deq__RDY=0. Repeat the fill/drain 3 times so the pointers wrap (DEPTH=3 build too) -> data stays FIFO-ordered.
- Simultaneous enq+deq at count=2 (contents 0x10,0x11): enq 0x12 with deq -> out_count=2, out_first=0x11, next deq gives 0x12.
- Deq on empty and enq on full with ENA held high 5 cycles -> no pointer or count change. out_count stays 0 / DEPTH respectively.
- With FIFO_N_PIPELINE_FULL_EN, full FIFO holding 0xB0..0xB3: enq 0xB4 plus deq in the same cycle -> in_enq__RDY=1 that cycle, out_count=4, out_first=0xB1, and 0xB4 is dequeued fourth. Without the macro the same stimulus gives in_enq__RDY=0, 0xB4 is dropped and out_count=3.
